// File: rtl/vproc_vregwr_arb_pkg.sv
// Shared helpers for the vector register write-port arbiter and its grant logic.
package vproc_vregwr_arb_pkg;

  function automatic int unsigned port_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Circular increment that wraps at n, so non-power-of-two port counts work.
  function automatic int unsigned wrap_inc(int unsigned p, int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/vproc_rr_arbiter.sv
// Combinational round-robin grant: first requester found circularly after ptr.
module vproc_rr_arbiter import vproc_vregwr_arb_pkg::*; #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = port_idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int unsigned k;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    k         = 32'(ptr);
    // Visit ptr+1 .. ptr; the previous winner is searched last.
    for (int unsigned i = 0; i < N; i++) begin
      k = wrap_inc(k, N);
      if (!grant_vld && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vproc_vregwr_arb.sv
// Merges PORT_CNT vector register write ports onto one register-file port
// through a single valid/ready output stage with round-robin arbitration.
module vproc_vregwr_arb import vproc_vregwr_arb_pkg::*; #(
  parameter int unsigned PORT_CNT = 2,
  parameter int unsigned VPORT_W  = 128,
  parameter int unsigned VADDR_W  = 5
) (
  input  logic                              clk_i,
  input  logic                              async_rst_ni,
  input  logic [PORT_CNT-1:0]               req_valid_i,
  output logic [PORT_CNT-1:0]               req_ready_o,
  input  logic [PORT_CNT*VADDR_W-1:0]       req_addr_i,
  input  logic [PORT_CNT*VPORT_W/8-1:0]     req_be_i,
  input  logic [PORT_CNT*VPORT_W-1:0]       req_data_i,
  output logic                              vreg_wr_valid_o,
  input  logic                              vreg_wr_ready_i,
  output logic [VADDR_W-1:0]                vreg_wr_addr_o,
  output logic [VPORT_W/8-1:0]              vreg_wr_be_o,
  output logic [VPORT_W-1:0]                vreg_wr_data_o,
  output logic [$clog2(PORT_CNT)-1:0]       vreg_wr_src_o
);

  localparam int unsigned IDX_W = port_idx_w(PORT_CNT);
  localparam int unsigned BE_W  = VPORT_W / 8;

  logic [PORT_CNT-1:0][VADDR_W-1:0] addr_arr;
  logic [PORT_CNT-1:0][BE_W-1:0]    be_arr;
  logic [PORT_CNT-1:0][VPORT_W-1:0] data_arr;

  assign addr_arr = req_addr_i;
  assign be_arr   = req_be_i;
  assign data_arr = req_data_i;

  logic [IDX_W-1:0]    ptr_q, src_q, gidx;
  logic [PORT_CNT-1:0] grant;
  logic                gvld, stage_rdy, accept, out_valid_q;
  logic [VADDR_W-1:0]  addr_q;
  logic [BE_W-1:0]     be_q;
  logic [VPORT_W-1:0]  data_q;

  vproc_rr_arbiter #(
    .N     (PORT_CNT),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid_i),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_vld (gvld)
  );

  // Stage accepts when empty or when the held write leaves this cycle.
  assign stage_rdy   = ~out_valid_q | vreg_wr_ready_i;
  assign req_ready_o = grant & {PORT_CNT{stage_rdy}};
  assign accept      = gvld & stage_rdy;

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      out_valid_q <= 1'b0;
      ptr_q       <= IDX_W'(PORT_CNT - 1);
      src_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      data_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ptr_q       <= gidx;
      src_q       <= gidx;
      addr_q      <= addr_arr[gidx];
      be_q        <= be_arr[gidx];
      data_q      <= data_arr[gidx];
    end else if (stage_rdy) begin
      out_valid_q <= 1'b0;
    end
  end

  assign vreg_wr_valid_o = out_valid_q;
  assign vreg_wr_addr_o  = addr_q;
  assign vreg_wr_be_o    = be_q;
  assign vreg_wr_data_o  = data_q;
  assign vreg_wr_src_o   = src_q;

endmodule

// File: tb/tb_vproc_vregwr_arb.sv
// Self-checking bench for vproc_vregwr_arb: directed scenarios plus random traffic
// compared cycle by cycle against a request-queue reference model.
module tb_vproc_vregwr_arb;
  localparam int N   = 3;
  localparam int VW  = 32;
  localparam int AW  = 5;
  localparam int BEW = VW / 8;
  localparam int SW  = $clog2(N);

  logic              clk = 1'b0;
  logic              async_rst_ni = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N*AW-1:0]   req_addr_i = '0;
  logic [N*BEW-1:0]  req_be_i = '0;
  logic [N*VW-1:0]   req_data_i = '0;
  logic              vreg_wr_valid_o;
  logic              vreg_wr_ready_i = 1'b0;
  logic [AW-1:0]     vreg_wr_addr_o;
  logic [BEW-1:0]    vreg_wr_be_o;
  logic [VW-1:0]     vreg_wr_data_o;
  logic [SW-1:0]     vreg_wr_src_o;

  vproc_vregwr_arb #(.PORT_CNT(N), .VPORT_W(VW), .VADDR_W(AW)) dut (
    .clk_i(clk), .async_rst_ni(async_rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_data_i(req_data_i),
    .vreg_wr_valid_o(vreg_wr_valid_o), .vreg_wr_ready_i(vreg_wr_ready_i),
    .vreg_wr_addr_o(vreg_wr_addr_o), .vreg_wr_be_o(vreg_wr_be_o),
    .vreg_wr_data_o(vreg_wr_data_o), .vreg_wr_src_o(vreg_wr_src_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester side: one pending request per port, held until accepted.
  bit              v[N];
  logic [AW-1:0]   ra[N];
  logic [BEW-1:0]  rb[N];
  logic [VW-1:0]   rd[N];
  bit              wr_rdy;

  // Reference model: last granted port and contents of the register-file write.
  int              m_ptr;
  bit              m_vld;
  logic [AW-1:0]   m_addr;
  logic [BEW-1:0]  m_be;
  logic [VW-1:0]   m_data;
  int              m_src;

  logic [N-1:0]    obs_rdy;
  int              obs_idx;
  int              waits[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]           = v[k];
      req_addr_i[k*AW +: AW]   = ra[k];
      req_be_i[k*BEW +: BEW]   = rb[k];
      req_data_i[k*VW +: VW]   = rd[k];
    end
    vreg_wr_ready_i = wr_rdy;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [BEW-1:0] b, input logic [VW-1:0] d);
    v[k] = 1'b1; ra[k] = a; rb[k] = b; rd[k] = d;
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_ptr = N - 1; m_addr = '0; m_be = '0; m_data = '0; m_src = 0;
    for (int k = 0; k < N; k++) v[k] = 1'b0;
  endtask

  // One clock: drive inputs, check ready, advance model at the edge, check outputs.
  task automatic cycle();
    int g;
    bit srdy;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (v[k] && g < 0) g = k;
    end
    srdy = !m_vld || wr_rdy;
    exp_rdy = (g >= 0 && srdy) ? N'(1 << g) : '0;
    obs_rdy = req_ready_o;
    obs_idx = -1;
    for (int k = 0; k < N; k++) if (obs_rdy[k] && obs_idx < 0) obs_idx = k;
    chk("req_ready", obs_rdy, exp_rdy);
    @(posedge clk);
    if (exp_rdy != 0) begin
      m_vld = 1'b1; m_addr = ra[g]; m_be = rb[g]; m_data = rd[g]; m_src = g; m_ptr = g;
      v[g] = 1'b0;
    end else if (srdy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
    chk("wr_valid", vreg_wr_valid_o, m_vld);
    if (m_vld) begin
      chk("wr_addr", vreg_wr_addr_o, m_addr);
      chk("wr_be", vreg_wr_be_o, m_be);
      chk("wr_data", vreg_wr_data_o, m_data);
      chk("wr_src", vreg_wr_src_o, m_src);
    end
  endtask

  task automatic do_reset();
    async_rst_ni = 1'b0;
    model_reset();
    wr_rdy = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst_ni = 1'b1;
  endtask

  // Requester obligation: a stalled request stays valid and unchanged.
  logic [N-1:0]     pend;
  logic [N*AW-1:0]  s_addr;
  logic [N*BEW-1:0] s_be;
  logic [N*VW-1:0]  s_data;
  initial pend = '0;
  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (async_rst_ni && pend[k])
        assert (req_valid_i[k] && req_addr_i[k*AW +: AW] == s_addr[k*AW +: AW]
                && req_be_i[k*BEW +: BEW] == s_be[k*BEW +: BEW] && req_data_i[k*VW +: VW] == s_data[k*VW +: VW])
          else $error("requester %0d changed its request before acceptance", k);
    pend   <= async_rst_ni ? (req_valid_i & ~req_ready_o) : '0;
    s_addr <= req_addr_i;
    s_be   <= req_be_i;
    s_data <= req_data_i;
  end

  initial begin
    model_reset();
    wr_rdy = 1'b0;
    for (int k = 0; k < N; k++) begin ra[k] = '0; rb[k] = '0; rd[k] = '0; end
    drive();

    // Reset state: registered outputs zero, ready follows grant with empty stage.
    @(negedge clk);
    v[0] = 1'b1; v[1] = 1'b1;
    drive();
    #1;
    chk("rst_wr_valid", vreg_wr_valid_o, 0);
    chk("rst_wr_addr", vreg_wr_addr_o, 0);
    chk("rst_wr_be", vreg_wr_be_o, 0);
    chk("rst_wr_data", vreg_wr_data_o, 0);
    chk("rst_wr_src", vreg_wr_src_o, 0);
    chk("rst_req_ready", req_ready_o, 3'b001);

    // Post-reset priority, then idle drain.
    do_reset();
    wr_rdy = 1'b1;
    set_req(0, 5'd1, 4'h3, 32'hA0A0_0001);
    set_req(1, 5'd2, 4'hC, 32'hB1B1_0002);
    cycle();
    chk("pr_grant0", obs_rdy, 3'b001);
    chk("pr_src0", vreg_wr_src_o, 0);
    chk("pr_data0", vreg_wr_data_o, 32'hA0A0_0001);
    cycle();
    chk("pr_grant1", obs_rdy, 3'b010);
    chk("pr_src1", vreg_wr_src_o, 1);
    cycle();
    chk("drain_valid", vreg_wr_valid_o, 0);

    // Round-robin with all ports continuously valid.
    do_reset();
    wr_rdy = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, AW'(k + 10), '1, VW'(k));
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("rr_order", obs_idx, i % 3);
      if (obs_idx >= 0) set_req(obs_idx, AW'(i), '1, VW'(i));
    end

    // Back-pressure: held write frozen, nobody ready, then port 0 wins.
    do_reset();
    wr_rdy = 1'b1;
    set_req(1, 5'd5, '1, 32'h5555_5555);
    cycle();
    chk("bp_first", obs_rdy, 3'b010);
    wr_rdy = 1'b0;
    set_req(0, 5'd9, 4'h1, 32'h0909_0909);
    set_req(1, 5'd6, 4'h2, 32'h0606_0606);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", obs_rdy, 0);
      chk("bp_addr", vreg_wr_addr_o, 5);
      chk("bp_be", vreg_wr_be_o, 4'hF);
    end
    wr_rdy = 1'b1;
    cycle();
    chk("bp_regrant", obs_rdy, 3'b001);
    chk("bp_new_addr", vreg_wr_addr_o, 9);

    // Lone requester granted every cycle.
    do_reset();
    wr_rdy = 1'b1;
    for (int a = 2; a <= 5; a++) begin
      set_req(1, AW'(a), 4'hF, VW'(a * 17));
      cycle();
      chk("single_rdy", obs_rdy, 3'b010);
      chk("single_addr", vreg_wr_addr_o, a);
    end

    // Asynchronous reset while a write is stalled.
    do_reset();
    wr_rdy = 1'b1;
    set_req(2, 5'd7, 4'h7, 32'h7777_0000);
    cycle();
    wr_rdy = 1'b0;
    set_req(1, 5'd8, 4'h8, 32'h8888_0000);
    cycle();
    chk("mid_valid_before", vreg_wr_valid_o, 1);
    #2;
    async_rst_ni = 1'b0;
    #1;
    chk("mid_valid_dropped", vreg_wr_valid_o, 0);
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst_ni = 1'b1;
    wr_rdy = 1'b1;
    set_req(0, 5'd3, 4'h1, 32'h1);
    set_req(1, 5'd4, 4'h2, 32'h2);
    cycle();
    chk("mid_prio", obs_rdy, 3'b001);

    // Random traffic against the model, with a per-port wait bound.
    do_reset();
    for (int k = 0; k < N; k++) waits[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      bit pre[N];
      for (int k = 0; k < N; k++)
        if (!v[k] && ($urandom % 3 != 0))
          set_req(k, AW'($urandom), BEW'($urandom), VW'($urandom));
      wr_rdy = ($urandom % 4 != 0);
      for (int k = 0; k < N; k++) pre[k] = v[k];
      cycle();
      if (obs_idx >= 0) begin
        chk("fair_wait", (waits[obs_idx] <= N - 1), 1);
        waits[obs_idx] = 0;
        for (int k = 0; k < N; k++) if (pre[k] && k != obs_idx) waits[k]++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vproc_vregwr_arb.md
# vproc_vregwr_arb

Round-robin write-port arbiter that merges the vector register write ports of several result-packing stages onto a single register-file write port. It sits directly downstream of the per-unit packing stages and directly upstream of the vector register file. It adds one register stage with a valid/ready handshake so that a busy register file back-pressures every requester. It provides starvation-free access and in-order delivery per requester.

## Interface
- `PORT_CNT`, 2: number of requesting write ports; at least 2.
- `VPORT_W`, 128: write data width in bits; a multiple of 8.
- `VADDR_W`, 5: vector register address width.
- `clk_i`  in  1  clock.
- `async_rst_ni`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  PORT_CNT  per-port write request valid.
- `req_ready_o`  out  PORT_CNT  per-port request accepted this cycle.
- `req_addr_i`  in  PORT_CNT*VADDR_W  per-port address; port k occupies bits [k*VADDR_W +: VADDR_W].
- `req_be_i`  in  PORT_CNT*VPORT_W/8  per-port byte enables.
- `req_data_i`  in  PORT_CNT*VPORT_W  per-port write data.
- `vreg_wr_valid_o`  out  1  register-file write valid.
- `vreg_wr_ready_i`  in  1  register file accepts the write.
- `vreg_wr_addr_o`  out  VADDR_W  write address.
- `vreg_wr_be_o`  out  VPORT_W/8  byte enables.
- `vreg_wr_data_o`  out  VPORT_W  write data.
- `vreg_wr_src_o`  out  $clog2(PORT_CNT)  index of the port that issued the current write.

## Operation
- **Output register.** The block holds `out_valid_q`, `addr`, `be`, `data` and `src`. All are reset to 0.
- **Round-robin pointer.** `ptr_q` is reset to `PORT_CNT-1`, so port 0 has first priority after reset.
- **Grant.** The grant goes to the first port with `req_valid_i` set, searching circularly from `ptr_q+1` to `ptr_q`. Exactly one bit or zero bits are granted.
- **Stage ready.** `stage_rdy = ~out_valid_q | vreg_wr_ready_i`.
- **Request ready.** `req_ready_o[k] = grant[k] & stage_rdy`. Ready for a port never depends on its own valid except through the grant.
- **Acceptance.** A request is accepted when `req_valid_i[k] & req_ready_o[k]`. On acceptance:
  - addr, be, data and src load from port k;
  - `out_valid_q` is set to 1;
  - `ptr_q` is set to k.
- **Draining.** When `stage_rdy` holds and no port is valid, `out_valid_q` is cleared. Data registers hold their values.
- **Output contents.** Outputs are driven straight from the registers. Addr, be, data and src are don't-care while valid is low.
- **No combining.** Writes are never merged or reordered. Two ports writing the same address are delivered in grant order.
- **Requester obligations.**
  - Requests must remain stable while valid and not ready; this is checked by assertion in the bench.
  - `req_valid_i` may not be withdrawn before acceptance.

## Timing
- **Latency.** A request accepted in cycle N appears on `vreg_wr_*_o` in cycle N+1.
- **Throughput.** With `vreg_wr_ready_i` held at 1, one write completes per cycle.
- **Fairness.** Under continuous requests from all ports, each port is granted exactly once every `PORT_CNT` cycles. Worst-case wait is `PORT_CNT-1` acceptances.
- **Back-pressure.** While `out_valid_q & ~vreg_wr_ready_i`:
  - all `req_ready_o` are 0;
  - outputs and `ptr_q` are frozen.
- **Simultaneous events.** In the same cycle the register file may consume the held write and a new request may be accepted. The new write then replaces the old one with no bubble.
- **Single requester.** A lone requester is granted every cycle regardless of `ptr_q`.
- **Reset mid-operation.** Asynchronous assertion immediately has these effects:
  - `vreg_wr_valid_o` drops to 0;
  - `req_ready_o` follows the grant with `stage_rdy = 1`;
  - the pending write is lost, and requesters are reset by the same signal.
- **Reset values.** All outputs read 0 in reset, except `req_ready_o`, which is combinational.

## Structure
- **Shared package.** No new typedefs are needed in `vproc_pkg`. The arbiter is parameter-only.
- **Sub-module `vproc_rr_arbiter`.** This holds the combinational circular priority grant from the request vector and the pointer. It is reusable for the read-port arbitration. The pointer register stays in `vproc_vregwr_arb`.
- **Port indexing.** The src width uses `$clog2(PORT_CNT)`. Power-of-two `PORT_CNT` is not required; the pointer wraps from `PORT_CNT-1` to 0.

## Test plan
- **Post-reset priority.** Ports 0 and 1 are both valid with `vreg_wr_ready_i=1`. Required: port 0 is accepted in cycle 0 and port 1 in cycle 1. Write data appears at cycles 1 and 2 with `vreg_wr_src_o` = 0 then 1.
- **Round-robin.** `PORT_CNT=3`, all three ports continuously valid for 9 cycles. Required: grant order is 0,1,2,0,1,2,0,1,2, and no port waits more than 2 cycles.
- **Back-pressure.** Port 1 is accepted with addr=5 and be=all-ones, then `vreg_wr_ready_i=0` for 3 cycles. Required:
  - addr 5 is held on the outputs for 3 cycles;
  - `req_ready_o=0` throughout;
  - when ready rises, the next grant goes to port 0 and is accepted in the same cycle.
- **Single requester.** Only port 1 is valid for 4 consecutive requests (addr 2,3,4,5). Required: 4 writes in 4 consecutive cycles, in order.
- **Idle drain.** After one write with no further requests, `vreg_wr_valid_o` is 1 for exactly one cycle, then 0.
- **Reset mid-transfer.** `async_rst_ni` is asserted while `out_valid_q=1` and ready=0. Required: valid drops to 0 immediately. After release, port 0 has priority again.
